// File: rtl/mult_controller_pkg.sv
// -----------------------------------------------------------------------------
// mult_controller_pkg
// Shared definitions for the approximate-multiplier sequencing controller:
// state encoding (4-bit binary), batch size and the default watchdog limit.
// Optional feature macro: CTRL_WDOG_EN (loop watchdog in mult_controller).
// -----------------------------------------------------------------------------
package mult_controller_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_INIT    = 4'd1;
    localparam logic [3:0] ST_LOAD_A  = 4'd2;
    localparam logic [3:0] ST_LOAD_B  = 4'd3;
    localparam logic [3:0] ST_NORM_A  = 4'd4;
    localparam logic [3:0] ST_NORM_B  = 4'd5;
    localparam logic [3:0] ST_MULT    = 4'd6;
    localparam logic [3:0] ST_SHIFT_A = 4'd7;
    localparam logic [3:0] ST_SHIFT_B = 4'd8;
    localparam logic [3:0] ST_WRITE   = 4'd9;
    localparam logic [3:0] ST_DONE    = 4'd10;

    typedef enum logic [3:0] {
        IDLE    = ST_IDLE,
        INIT    = ST_INIT,
        LOAD_A  = ST_LOAD_A,
        LOAD_B  = ST_LOAD_B,
        NORM_A  = ST_NORM_A,
        NORM_B  = ST_NORM_B,
        MULT    = ST_MULT,
        SHIFT_A = ST_SHIFT_A,
        SHIFT_B = ST_SHIFT_B,
        WRITE   = ST_WRITE,
        DONE    = ST_DONE
    } state_t;

    // Fixed by the 3-bit output address counter in the datapath.
    localparam int NUM_PAIRS       = 8;
    localparam int WDOG_CYCLES_DEF = 16;

    // States that wait on a datapath status input and may repeat.
    function automatic logic is_loop_state(input state_t s);
        return (s == NORM_A) || (s == NORM_B) || (s == SHIFT_A) || (s == SHIFT_B);
    endfunction

endpackage

// File: rtl/mult_controller_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// mult_controller_ctrl_wdog
// Loop watchdog: a down-counter loaded with WDOG_CYCLES-1 on clr and
// decremented while en is high. expired flags the cycle in which the loop
// state has been held for WDOG_CYCLES cycles (terminal count 0 with en high).
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   clr      reload the counter (asserted on the cycle before loop entry)
//   en       count enable (high while in a loop state)
//   expired  terminal count reached in the current cycle
// -----------------------------------------------------------------------------
module mult_controller_ctrl_wdog #(
    parameter int WDOG_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= LOAD_VAL;
        end else if (clr) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/mult_controller.sv
// -----------------------------------------------------------------------------
// mult_controller
// Sequencing FSM for the approximate-multiplier datapath. For each of the
// NUM_PAIRS operand pairs it loads A and B, normalises both, multiplies the
// top bytes, shifts the product right and writes it to the output RAM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start, all strobes low
//   INIT    | clear address counters 1 and 4
//   LOAD_A  | load operand A, advance input address
//   LOAD_B  | load operand B, advance input address, clear shift counters
//   NORM_A  | shift A left until countdone1
//   NORM_B  | shift B left until countdone2
//   MULT    | load multiplier inputs and product register
//   SHIFT_A | shift product right until carry2
//   SHIFT_B | shift product right until carry3
//   WRITE   | write product; last pair when carry4
//   DONE    | one-cycle done pulse
//
// Ports: clk/rst (async active-low), start/busy/done/err host handshake,
// countdone1/2 and carry2..4 datapath status, ld1..ld5, Inc1..Inc4,
// Countrst1..Countrst4, Shle1/Shle2/Shre shift enables, We write enable.
// Optional feature macro: CTRL_WDOG_EN (loop watchdog, drives err).
// -----------------------------------------------------------------------------
module mult_controller
    import mult_controller_pkg::*;
#(
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err,
    input  logic countdone1,
    input  logic countdone2,
    input  logic carry2,
    input  logic carry3,
    input  logic carry4,
    output logic ld1,
    output logic ld2,
    output logic ld3,
    output logic ld4,
    output logic ld5,
    output logic Inc1,
    output logic Inc2,
    output logic Inc3,
    output logic Inc4,
    output logic Countrst1,
    output logic Countrst2,
    output logic Countrst3,
    output logic Countrst4,
    output logic Shle1,
    output logic Shle2,
    output logic Shre,
    output logic We
);

    state_t state, next_state;
    logic   wdog_expired;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A loop's normal exit condition wins over a same-cycle watchdog expiry.
    always_comb begin
        next_state = state;
        done       = 1'b0;
        ld1        = 1'b0;
        ld2        = 1'b0;
        ld3        = 1'b0;
        ld4        = 1'b0;
        ld5        = 1'b0;
        Inc1       = 1'b0;
        Inc2       = 1'b0;
        Inc3       = 1'b0;
        Inc4       = 1'b0;
        Countrst1  = 1'b0;
        Countrst2  = 1'b0;
        Countrst3  = 1'b0;
        Countrst4  = 1'b0;
        Shle1      = 1'b0;
        Shle2      = 1'b0;
        Shre       = 1'b0;
        We         = 1'b0;
        case (state)
            IDLE: if (start) next_state = INIT;
            INIT: begin
                Countrst1  = 1'b1;
                Countrst4  = 1'b1;
                next_state = LOAD_A;
            end
            LOAD_A: begin
                ld1        = 1'b1;
                Inc1       = 1'b1;
                next_state = LOAD_B;
            end
            LOAD_B: begin
                ld2        = 1'b1;
                Inc1       = 1'b1;
                Countrst2  = 1'b1;
                Countrst3  = 1'b1;
                next_state = NORM_A;
            end
            NORM_A: begin
                if (countdone1)        next_state = NORM_B;
                else if (wdog_expired) next_state = DONE;
                else begin
                    Shle1 = 1'b1;
                    Inc2  = 1'b1;
                end
            end
            NORM_B: begin
                if (countdone2)        next_state = MULT;
                else if (wdog_expired) next_state = DONE;
                else begin
                    Shle2 = 1'b1;
                    Inc3  = 1'b1;
                end
            end
            MULT: begin
                ld3        = 1'b1;
                ld4        = 1'b1;
                ld5        = 1'b1;
                next_state = SHIFT_A;
            end
            SHIFT_A: begin
                if (carry2)            next_state = SHIFT_B;
                else if (wdog_expired) next_state = DONE;
                else begin
                    Shre = 1'b1;
                    Inc2 = 1'b1;
                end
            end
            SHIFT_B: begin
                if (carry3)            next_state = WRITE;
                else if (wdog_expired) next_state = DONE;
                else begin
                    Shre = 1'b1;
                    Inc3 = 1'b1;
                end
            end
            WRITE: begin
                We = 1'b1;
                if (carry4) next_state = DONE;
                else begin
                    Inc4       = 1'b1;
                    next_state = LOAD_A;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

`ifdef CTRL_WDOG_EN
    logic err_q;

    // Reload on every state change so each loop state gets a fresh budget.
    mult_controller_ctrl_wdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (next_state != state),
        .en      (is_loop_state(state)),
        .expired (wdog_expired)
    );

    // Only a watchdog abort moves a loop state straight to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((state == IDLE) && start) begin
            err_q <= 1'b0;
        end else if (is_loop_state(state) && (next_state == DONE)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_wdog_cfg;

    assign wdog_expired    = 1'b0;
    assign err             = 1'b0;
    assign unused_wdog_cfg = (WDOG_CYCLES > 0);
`endif

endmodule

// File: tb/tb_mult_controller.sv
// -----------------------------------------------------------------------------
// tb_mult_controller
// Directed bench for mult_controller. A per-batch expected trace is built from
// the pair loop counts (how many cycles each datapath status stays low), then
// replayed: each cycle drives start/status and compares all outputs. Count
// checks against hand-computed literals pin the trace builder itself.
// Optional feature macro: CTRL_WDOG_EN (adds the watchdog scenario).
// -----------------------------------------------------------------------------
module tb_mult_controller;
    import mult_controller_pkg::*;

    localparam int WDOG = 16;

    // Output vector bit positions.
    localparam logic [19:0] O_BUSY  = 20'h80000;
    localparam logic [19:0] O_DONE  = 20'h40000;
    localparam logic [19:0] O_ERR   = 20'h20000;
    localparam logic [19:0] O_LD1   = 20'h10000;
    localparam logic [19:0] O_LD2   = 20'h08000;
    localparam logic [19:0] O_LD3   = 20'h04000;
    localparam logic [19:0] O_LD4   = 20'h02000;
    localparam logic [19:0] O_LD5   = 20'h01000;
    localparam logic [19:0] O_INC1  = 20'h00800;
    localparam logic [19:0] O_INC2  = 20'h00400;
    localparam logic [19:0] O_INC3  = 20'h00200;
    localparam logic [19:0] O_INC4  = 20'h00100;
    localparam logic [19:0] O_CR1   = 20'h00080;
    localparam logic [19:0] O_CR2   = 20'h00040;
    localparam logic [19:0] O_CR3   = 20'h00020;
    localparam logic [19:0] O_CR4   = 20'h00010;
    localparam logic [19:0] O_SHLE1 = 20'h00008;
    localparam logic [19:0] O_SHLE2 = 20'h00004;
    localparam logic [19:0] O_SHRE  = 20'h00002;
    localparam logic [19:0] O_WE    = 20'h00001;

    // Status input bits: {countdone1, countdone2, carry2, carry3, carry4}.
    localparam logic [4:0] I_CD1 = 5'b10000;
    localparam logic [4:0] I_CD2 = 5'b01000;
    localparam logic [4:0] I_C2  = 5'b00100;
    localparam logic [4:0] I_C3  = 5'b00010;
    localparam logic [4:0] I_C4  = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic countdone1 = 1'b0, countdone2 = 1'b0, carry2 = 1'b0, carry3 = 1'b0, carry4 = 1'b0;
    logic busy, done, err;
    logic ld1, ld2, ld3, ld4, ld5;
    logic Inc1, Inc2, Inc3, Inc4;
    logic Countrst1, Countrst2, Countrst3, Countrst4;
    logic Shle1, Shle2, Shre, We;

    always #5 clk = ~clk;

    mult_controller #(.WDOG_CYCLES(WDOG)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .countdone1 (countdone1),
        .countdone2 (countdone2),
        .carry2     (carry2),
        .carry3     (carry3),
        .carry4     (carry4),
        .ld1        (ld1),
        .ld2        (ld2),
        .ld3        (ld3),
        .ld4        (ld4),
        .ld5        (ld5),
        .Inc1       (Inc1),
        .Inc2       (Inc2),
        .Inc3       (Inc3),
        .Inc4       (Inc4),
        .Countrst1  (Countrst1),
        .Countrst2  (Countrst2),
        .Countrst3  (Countrst3),
        .Countrst4  (Countrst4),
        .Shle1      (Shle1),
        .Shle2      (Shle2),
        .Shre       (Shre),
        .We         (We)
    );

    typedef struct {
        bit          st;
        logic [4:0]  ins;
        logic [19:0] exp;
    } ent_t;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   err_m = 1'b0;
    int   na[8], nb[8], sa[8], sb[8];
    int   c_we, c_inc4, c_inc1, c_inc2, c_busy, c_shle1, c_shle2, c_cr1, c_done, c_err_done, done_at;

    function automatic logic [19:0] got_vec();
        return {busy, done, err, ld1, ld2, ld3, ld4, ld5, Inc1, Inc2, Inc3, Inc4,
                Countrst1, Countrst2, Countrst3, Countrst4, Shle1, Shle2, Shre, We};
    endfunction

    function automatic bit rs();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %05h expected %05h", name, $time, got, exp);
        end
    endtask

    // Irrelevant status bits are randomised so decode must ignore them.
    task automatic add(input bit st, input logic [4:0] mask, input logic [4:0] val, input logic [19:0] o);
        ent_t e;
        logic [4:0] r;
        r     = 5'($urandom);
        e.st  = st;
        e.ins = (r & ~mask) | (val & mask);
        e.exp = o | (err_m ? O_ERR : 20'h0);
        q.push_back(e);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 5'b0, 5'b0, 20'h0);
    endtask

    // n cycles with the status low, then one exit cycle with it high.
    task automatic loop_seg(input int n, input logic [4:0] sel, input logic [19:0] strobes, output bit abort);
        abort = 1'b0;
`ifdef CTRL_WDOG_EN
        if (n >= WDOG) begin
            for (int i = 0; i < WDOG - 1; i++) add(rs(), sel, 5'b0, O_BUSY | strobes);
            add(rs(), sel, 5'b0, O_BUSY);
            err_m = 1'b1;
            abort = 1'b1;
            return;
        end
`endif
        for (int i = 0; i < n; i++) add(rs(), sel, 5'b0, O_BUSY | strobes);
        add(rs(), sel, sel, O_BUSY);
    endtask

    task automatic gen_batch(input int np, input bit done_start);
        bit ab;
        bit last;
        add(1'b1, 5'b0, 5'b0, 20'h0);
        err_m = 1'b0;
        add(rs(), 5'b0, 5'b0, O_BUSY | O_CR1 | O_CR4);
        for (int p = 0; p < np; p++) begin
            add(rs(), 5'b0, 5'b0, O_BUSY | O_LD1 | O_INC1);
            add(rs(), 5'b0, 5'b0, O_BUSY | O_LD2 | O_INC1 | O_CR2 | O_CR3);
            loop_seg(na[p], I_CD1, O_SHLE1 | O_INC2, ab);
            if (ab) break;
            loop_seg(nb[p], I_CD2, O_SHLE2 | O_INC3, ab);
            if (ab) break;
            add(rs(), 5'b0, 5'b0, O_BUSY | O_LD3 | O_LD4 | O_LD5);
            loop_seg(sa[p], I_C2, O_SHRE | O_INC2, ab);
            if (ab) break;
            loop_seg(sb[p], I_C3, O_SHRE | O_INC3, ab);
            if (ab) break;
            last = (p == np - 1);
            add(rs(), I_C4, last ? I_C4 : 5'b0, O_BUSY | O_WE | (last ? 20'h0 : O_INC4));
        end
        add(done_start, 5'b0, 5'b0, O_BUSY | O_DONE | (err_m ? O_ERR : 20'h0));
    endtask

    task automatic clr_cfg();
        for (int i = 0; i < 8; i++) begin
            na[i] = 0; nb[i] = 0; sa[i] = 0; sb[i] = 0;
        end
    endtask

    task automatic clr_counts();
        c_we = 0; c_inc4 = 0; c_inc1 = 0; c_inc2 = 0; c_busy = 0; c_shle1 = 0;
        c_shle2 = 0; c_cr1 = 0; c_done = 0; c_err_done = 0; done_at = 0;
    endtask

    task automatic tally();
        if (busy) c_busy++;
        if (We) c_we++;
        if (Inc4) c_inc4++;
        if (Inc1) c_inc1++;
        if (Inc2) c_inc2++;
        if (Shle1) c_shle1++;
        if (Shle2) c_shle2++;
        if (Countrst1) c_cr1++;
        if (done) begin
            c_done++;
            done_at = c_busy;
            if (err) c_err_done++;
        end
    endtask

    task automatic run_n(input int n);
        ent_t e;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            start = e.st;
            {countdone1, countdone2, carry2, carry3, carry4} = e.ins;
            @(negedge clk);
            check("trace", got_vec(), e.exp);
            tally();
        end
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    initial begin
        clr_cfg();
        clr_counts();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", got_vec(), 20'h0);
        @(negedge clk);
        rst = 1'b1;

        // Single pair, every status immediately satisfied.
        gen_batch(1, 1'b0);
        add_idle(2);
        run_all();
        check("single_busy_cycles", 20'(c_busy), 20'd10);
        check("single_done_cycle", 20'(done_at), 20'd10);
        check("single_we_count", 20'(c_we), 20'd1);

        // NORM_A held for 3 cycles.
        clr_cfg();
        clr_counts();
        na[0] = 3;
        gen_batch(1, 1'b0);
        add_idle(1);
        run_all();
        check("norma_shle1_count", 20'(c_shle1), 20'd3);
        check("norma_inc2_count", 20'(c_inc2), 20'd3);
        check("norma_shle2_count", 20'(c_shle2), 20'd0);

        // Full 8-pair batch, start held through DONE, then a back-to-back pair.
        clr_cfg();
        clr_counts();
        for (int p = 0; p < 8; p++) begin
            na[p] = p % 4;
            nb[p] = (p * 3) % 5;
            sa[p] = (p + 1) % 3;
            sb[p] = p % 2;
        end
        gen_batch(NUM_PAIRS, 1'b1);
        run_all();
        check("batch8_we_count", 20'(c_we), 20'd8);
        check("batch8_inc4_count", 20'(c_inc4), 20'd7);
        check("batch8_inc1_count", 20'(c_inc1), 20'd16);
        check("batch8_busy_cycles", 20'(c_busy), 20'd105);
        check("batch8_countrst1", 20'(c_cr1), 20'd1);
        clr_cfg();
        gen_batch(1, 1'b0);
        add_idle(2);
        run_all();
        check("b2b_countrst1", 20'(c_cr1), 20'd2);
        check("b2b_done_pulses", 20'(c_done), 20'd2);

        // Reset asserted mid NORM_A.
        clr_cfg();
        clr_counts();
        na[0] = 10;
        gen_batch(1, 1'b0);
        run_n(6);
        check("pre_reset_shle1", 20'(Shle1), 20'd1);
        #2;
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check("reset_mid_outputs", got_vec(), 20'h0);
        q.delete();
        @(negedge clk);
        check("reset_held_outputs", got_vec(), 20'h0);
        rst = 1'b1;
        err_m = 1'b0;
        add_idle(3);
        run_all();

`ifdef CTRL_WDOG_EN
        // NORM_A never finishes: watchdog abort, then err cleared by next start.
        clr_cfg();
        clr_counts();
        na[0] = 40;
        gen_batch(1, 1'b0);
        add_idle(2);
        run_all();
        check("wdog_we_count", 20'(c_we), 20'd0);
        check("wdog_done_with_err", 20'(c_err_done), 20'd1);
        check("wdog_busy_cycles", 20'(c_busy), 20'd20);
        check("wdog_err_sticky", 20'(err), 20'd1);
        clr_cfg();
        gen_batch(1, 1'b0);
        add_idle(1);
        run_all();
        check("wdog_err_cleared", 20'(err), 20'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
